blur_img_engine: RTL and testbench

Parametrised successor to the single-mode image blur. It walks a WIDTH×HEIGHT source image held in BRAM, gathers each 3×3 window with edge clamping, and applies the 1-2-1/2-4-2/1-2-1 Gaussian internally. It then writes the result to a destination BRAM. It adds a configurable BRAM read latency, a copy mode and a blur-then-decimate-by-2 mode, which feeds the next SIFT octave.

---
 rtl/blur_pkg.sv | 38 +++
 rtl/blur_addr_gen.sv | 55 +++++
 rtl/blur_img_engine.sv | 204 ++++++++++++++++++++
 tb/tb_blur_img_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 Gaussian blur engine.
package blur_pkg;

    typedef enum logic [1:0] {
        BLUR     = 2'd0,
        COPY     = 2'd1,
        DECIMATE = 2'd2
    } blur_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE
    } blur_state_t;

    localparam int unsigned TAP_W        = 4;
    localparam int unsigned WEIGHT_W     = 3;
    localparam int unsigned KERNEL_TAPS  = 9;
    localparam int unsigned KERNEL_SHIFT = 4;
    localparam int unsigned ROUND_BIAS   = 1 << (KERNEL_SHIFT - 1);

    localparam logic [TAP_W-1:0] CENTER_TAP = 4'd4;
    localparam logic [TAP_W-1:0] LAST_TAP   = 4'd8;

    // Row-major 1-2-1 / 2-4-2 / 1-2-1 kernel, weights sum to 16.
    localparam logic [WEIGHT_W-1:0] KERNEL_W [KERNEL_TAPS] = '{
        3'd1, 3'd2, 3'd1,
        3'd2, 3'd4, 3'd2,
        3'd1, 3'd2, 3'd1
    };

    typedef struct packed {
        logic             valid;
        logic [TAP_W-1:0] k;
    } tap_entry_t;

endpackage

// File: rtl/blur_addr_gen.sv
// Combinational edge-clamped source address for tap k of the 3x3 window centred at (x, y).
module blur_addr_gen
    import blur_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64
) (
    input  logic [$clog2(WIDTH)-1:0]        x_in,
    input  logic [$clog2(HEIGHT)-1:0]       y_in,
    input  logic [TAP_W-1:0]                k_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] addr_c
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned AW = $clog2(WIDTH * HEIGHT);

    logic [1:0]    col;
    logic [1:0]    row;
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;

    // Column/row offset selectors: 0 = -1, 1 = 0, 2 = +1.
    always_comb begin
        col = 2'd1;
        row = 2'd1;
        case (k_in)
            4'd0:    begin col = 2'd0; row = 2'd0; end
            4'd1:    begin col = 2'd1; row = 2'd0; end
            4'd2:    begin col = 2'd2; row = 2'd0; end
            4'd3:    begin col = 2'd0; row = 2'd1; end
            4'd5:    begin col = 2'd2; row = 2'd1; end
            4'd6:    begin col = 2'd0; row = 2'd2; end
            4'd7:    begin col = 2'd1; row = 2'd2; end
            4'd8:    begin col = 2'd2; row = 2'd2; end
            default: begin col = 2'd1; row = 2'd1; end
        endcase
    end

    always_comb begin
        tx = x_in;
        ty = y_in;
        if (col == 2'd0 && x_in != '0)
            tx = x_in - XW'(1);
        else if (col == 2'd2 && x_in != XW'(WIDTH - 1))
            tx = x_in + XW'(1);
        if (row == 2'd0 && y_in != '0)
            ty = y_in - YW'(1);
        else if (row == 2'd2 && y_in != YW'(HEIGHT - 1))
            ty = y_in + YW'(1);
    end

    assign addr_c = AW'(tx) + AW'(ty) * AW'(WIDTH);

endmodule

// File: rtl/blur_img_engine.sv
// BRAM-to-BRAM 3x3 Gaussian blur with copy and blur+decimate-by-2 modes.
// Define BLUR_ROUND_EN for round-half-up output; default truncates.
module blur_img_engine
    import blur_pkg::*;
#(
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    input  logic [1:0]                      mode_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] read_addr,
    output logic                            read_addr_valid,
    input  logic [BIT_DEPTH-1:0]            pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] write_addr,
    output logic                            write_valid,
    output logic [BIT_DEPTH-1:0]            pixel_out,
    output logic                            busy_out,
    output logic                            blur_done,
    output logic                            error_out
);

    localparam int unsigned XW    = $clog2(WIDTH);
    localparam int unsigned YW    = $clog2(HEIGHT);
    localparam int unsigned AW    = $clog2(WIDTH * HEIGHT);
    localparam int unsigned ACC_W = BIT_DEPTH + 4;
    localparam int unsigned DW    = 2;

    blur_state_t          state_q, state_d;
    blur_mode_t           mode_q, mode_d, start_mode;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [TAP_W-1:0]     k_q, k_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    tap_entry_t           pipe_q [READ_LATENCY];
    tap_entry_t           pipe_d [READ_LATENCY];
    logic [AW-1:0]        read_addr_q, read_addr_d;
    logic                 read_addr_valid_q, read_addr_valid_d;
    logic [AW-1:0]        write_addr_q, write_addr_d;
    logic                 write_valid_q, write_valid_d;
    logic [BIT_DEPTH-1:0] pixel_out_q, pixel_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    tap_entry_t           arrive;
    logic [ACC_W-1:0]     weighted;
    logic [ACC_W-1:0]     acc_sum;
    logic [ACC_W-1:0]     acc_out;
    logic                 last_x;
    logic                 last_y;
    logic [AW-1:0]        tap_addr_c;

    blur_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr_gen (
        .x_in   (x_d),
        .y_in   (y_d),
        .k_in   (k_d),
        .addr_c (tap_addr_c)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q           <= IDLE;
            mode_q            <= BLUR;
            x_q               <= '0;
            y_q               <= '0;
            k_q               <= '0;
            drain_q           <= '0;
            acc_q             <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
            read_addr_q       <= '0;
            read_addr_valid_q <= 1'b0;
            write_addr_q      <= '0;
            write_valid_q     <= 1'b0;
            pixel_out_q       <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            mode_q            <= mode_d;
            x_q               <= x_d;
            y_q               <= y_d;
            k_q               <= k_d;
            drain_q           <= drain_d;
            acc_q             <= acc_d;
            pipe_q            <= pipe_d;
            read_addr_q       <= read_addr_d;
            read_addr_valid_q <= read_addr_valid_d;
            write_addr_q      <= write_addr_d;
            write_valid_q     <= write_valid_d;
            pixel_out_q       <= pixel_out_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_q           <= error_d;
        end
    end

    // Tap index travels alongside its read so the returning pixel picks up the right weight.
    always_comb begin
        pipe_d[0] = '{valid: read_addr_valid_q, k: k_q};
        for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        x_d           = x_q;
        y_d           = y_q;
        k_d           = k_q;
        drain_d       = drain_q;
        write_addr_d  = write_addr_q;
        write_valid_d = 1'b0;
        pixel_out_d   = pixel_out_q;
        done_d        = 1'b0;
        error_d       = start_in && (state_q != IDLE);

        start_mode = (mode_in == 2'd3) ? BLUR : blur_mode_t'(mode_in);
        arrive     = pipe_q[READ_LATENCY-1];
        weighted   = ACC_W'(pixel_in) * ACC_W'(KERNEL_W[arrive.k]);
        acc_sum    = arrive.valid ? (acc_q + weighted) : acc_q;
        acc_d      = acc_sum;
`ifdef BLUR_ROUND_EN
        acc_out    = acc_sum + ACC_W'(ROUND_BIAS);
`else
        acc_out    = acc_sum;
`endif
        last_x     = (mode_q == DECIMATE) ? (x_q == XW'(WIDTH - 2)) : (x_q == XW'(WIDTH - 1));
        last_y     = (mode_q == DECIMATE) ? (y_q == YW'(HEIGHT - 2)) : (y_q == YW'(HEIGHT - 1));

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    mode_d  = start_mode;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = (start_mode == COPY) ? CENTER_TAP : '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mode_q == COPY || k_q == LAST_TAP) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + TAP_W'(1);
                end
            end
            DRAIN: begin
                // Last tap lands in this cycle; fold it in directly so the result is ready for WRITE.
                if (drain_q == DW'(READ_LATENCY - 1)) begin
                    write_valid_d = 1'b1;
                    write_addr_d  = (mode_q == DECIMATE)
                                  ? AW'(x_q >> 1) + AW'(y_q >> 1) * AW'(WIDTH / 2)
                                  : AW'(x_q) + AW'(y_q) * AW'(WIDTH);
                    pixel_out_d   = (mode_q == COPY) ? pixel_in
                                                     : BIT_DEPTH'(acc_out >> KERNEL_SHIFT);
                    state_d       = WRITE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            WRITE: begin
                if (last_x && last_y) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (last_x) begin
                        x_d = '0;
                        y_d = y_q + ((mode_q == DECIMATE) ? YW'(2) : YW'(1));
                    end else begin
                        x_d = x_q + ((mode_q == DECIMATE) ? XW'(2) : XW'(1));
                    end
                    k_d     = (mode_q == COPY) ? CENTER_TAP : '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign read_addr_valid_d = (state_d == FETCH);
    assign read_addr_d       = read_addr_valid_d ? tap_addr_c : read_addr_q;
    assign busy_d            = (state_d != IDLE);

    assign read_addr       = read_addr_q;
    assign read_addr_valid = read_addr_valid_q;
    assign write_addr      = write_addr_q;
    assign write_valid     = write_valid_q;
    assign pixel_out       = pixel_out_q;
    assign busy_out        = busy_q;
    assign blur_done       = done_q;
    assign error_out       = error_q;

endmodule

// File: tb/tb_blur_img_engine.sv
// Randomised self-checking bench for blur_img_engine on an 8x8 image against a behavioural blur model.
module tb_blur_img_engine;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int RL = 2;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_in;
    logic [1:0]    mode_in;
    logic [AW-1:0] read_addr;
    logic          read_addr_valid;
    logic [7:0]    pixel_in;
    logic [AW-1:0] write_addr;
    logic          write_valid;
    logic [7:0]    pixel_out;
    logic          busy_out;
    logic          blur_done;
    logic          error_out;

    logic [7:0] img [W*H];
    logic [7:0] rd_pipe [RL];
    int         wq_addr [$];
    int         wq_data [$];
    int         edge_cnt = 0;
    int         done_cnt = 0;
    int         done_edge = 0;
    int         start_edge = 0;
    int         checks = 0;
    int         errors = 0;

    blur_img_engine #(
        .BIT_DEPTH    (8),
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .start_in        (start_in),
        .mode_in         (mode_in),
        .read_addr       (read_addr),
        .read_addr_valid (read_addr_valid),
        .pixel_in        (pixel_in),
        .write_addr      (write_addr),
        .write_valid     (write_valid),
        .pixel_out       (pixel_out),
        .busy_out        (busy_out),
        .blur_done       (blur_done),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    // Source BRAM with RL-cycle read latency; unrequested cycles return noise.
    always @(posedge clk) begin
        rd_pipe[0] <= read_addr_valid ? img[read_addr] : 8'($urandom);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign pixel_in = rd_pipe[RL-1];

    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (write_valid) begin
            wq_addr.push_back(int'(write_addr));
            wq_data.push_back(int'(pixel_out));
        end
        if (blur_done) begin
            done_cnt++;
            done_edge = edge_cnt;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_blur(input int x, input int y);
        int acc, cx, cy, w;
        acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                cx = x + dx;
                cy = y + dy;
                if (cx < 0) cx = 0;
                if (cx > W - 1) cx = W - 1;
                if (cy < 0) cy = 0;
                if (cy > H - 1) cy = H - 1;
                w = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
                acc += w * int'(img[cx + cy * W]);
            end
        end
`ifdef BLUR_ROUND_EN
        acc += 8;
`endif
        return acc / 16;
    endfunction

    task automatic start_frame(input logic [1:0] m);
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        mode_in    = m;
        start_in   = 1'b1;
        start_edge = edge_cnt + 1;
        @(negedge clk);
        start_in   = 1'b0;
        check("busy_after_start", int'(busy_out), 1);
    endtask

    task automatic wait_done(input int prev, input int exp_cycles, input string tag);
        int n;
        n = 0;
        while (done_cnt == prev && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt != prev), 1);
        check({tag, "_cycles"}, done_edge - start_edge, exp_cycles);
        check({tag, "_busy_low_at_done"}, int'(busy_out), 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(blur_done), 0);
    endtask

    // mode: 0 blur, 1 copy, 2 decimate
    task automatic verify_frame(input int mode, input string tag);
        int n_exp, ex, ey, ev;
        n_exp = (mode == 2) ? (W * H / 4) : (W * H);
        check({tag, "_nwrites"}, wq_addr.size(), n_exp);
        for (int i = 0; i < wq_addr.size() && i < n_exp; i++) begin
            if (mode == 2) begin
                ex = 2 * (i % (W / 2));
                ey = 2 * (i / (W / 2));
            end else begin
                ex = i % W;
                ey = i / W;
            end
            ev = (mode == 1) ? int'(img[i]) : ref_blur(ex, ey);
            check($sformatf("%s_addr[%0d]", tag, i), wq_addr[i], i);
            check($sformatf("%s_pix(%0d,%0d)", tag, ex, ey), wq_data[i], ev);
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input int eff_mode, input int exp_cycles,
                             input string tag);
        int prev;
        prev = done_cnt;
        start_frame(m);
        wait_done(prev, exp_cycles, tag);
        verify_frame(eff_mode, tag);
    endtask

    initial begin
        int prev;
        rst_n    = 1'b0;
        start_in = 1'b0;
        mode_in  = 2'd0;
        for (int i = 0; i < W * H; i++) img[i] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_read_valid", int'(read_addr_valid), 0);
        check("rst_write_valid", int'(write_valid), 0);
        check("rst_outputs", int'({read_addr, write_addr, pixel_out, busy_out, blur_done, error_out}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy_out), 0);

        for (int i = 0; i < W * H; i++) img[i] = 8'd100;
        run_frame(2'd0, 0, W * H * (10 + RL), "flat");
        if (wq_data.size() == W * H) check("flat_value", wq_data[W*H-1], 100);

        for (int i = 0; i < W * H; i++) img[i] = 8'd0;
        img[3 + 3 * W] = 8'd2;
        run_frame(2'd0, 0, W * H * (10 + RL), "impulse");
        if (wq_data.size() == W * H) begin
`ifdef BLUR_ROUND_EN
            check("impulse_center", wq_data[3 + 3 * W], 1);
`else
            check("impulse_center", wq_data[3 + 3 * W], 0);
`endif
            check("impulse_side", wq_data[2 + 3 * W], 0);
        end

        for (int i = 0; i < W * H; i++) img[i] = 8'd0;
        img[0] = 8'd255;
        run_frame(2'd0, 0, W * H * (10 + RL), "corner");
        if (wq_data.size() == W * H) check("corner_00", wq_data[0], 143);

        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
        run_frame(2'd3, 0, W * H * (10 + RL), "rand_mode3");

        for (int i = 0; i < W * H; i++) img[i] = 8'((i % W) + W * (i / W));
        run_frame(2'd2, 2, (W * H / 4) * (10 + RL), "decim");
        if (wq_data.size() > 5) check("decim_addr5", wq_data[5], ref_blur(2, 2));

        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
        run_frame(2'd1, 1, W * H * (2 + RL), "copy");

        // Start while busy: flagged once, frame unaffected.
        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
        prev = done_cnt;
        start_frame(2'd0);
        repeat (50) @(negedge clk);
        start_in = 1'b1;
        mode_in  = 2'd1;
        @(negedge clk);
        start_in = 1'b0;
        check("err_pulse", int'(error_out), 1);
        @(negedge clk);
        check("err_one_cycle", int'(error_out), 0);
        wait_done(prev, W * H * (10 + RL), "busy_start");
        verify_frame(0, "busy_start");

        // Reset mid-frame abandons everything immediately.
        start_frame(2'd0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_read_valid", int'(read_addr_valid), 0);
        check("midrst_write_valid", int'(write_valid), 0);
        check("midrst_busy", int'(busy_out), 0);
        check("midrst_outputs", int'({read_addr, write_addr, pixel_out, blur_done, error_out}), 0);
        prev = done_cnt;
        repeat (4) @(negedge clk);
        wq_addr.delete();
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt, prev);
        check("midrst_no_writes", wq_addr.size(), 0);
        check("midrst_idle", int'(busy_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
